// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned GAP_CYCLES_DEF = 16;
  localparam int unsigned GRANT_W        = 3;
  localparam int unsigned GAP_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_i+1 upward (mod NREQ).
// With UART_SCHED_PRIORITY_EN defined, requester 0 pre-empts the rotation.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]    req_i,
  input  logic [GRANT_W-1:0] last_i,
  output logic [NREQ-1:0]    gnt_c_o,
  output logic [GRANT_W-1:0] idx_c_o,
  output logic               any_c_o
);

  // Pick the first active request after the previous winner
  always_comb begin
    logic [NREQ-1:0] req_sh;
    int unsigned     cand;
    req_sh  = '0;
    cand    = 0;
    gnt_c_o = '0;
    idx_c_o = '0;
    any_c_o = 1'b0;
`ifdef UART_SCHED_PRIORITY_EN
    if (req_i[0]) begin
      gnt_c_o = NREQ'(1);
      any_c_o = 1'b1;
    end else begin
`else
    begin
`endif
      for (int unsigned k = 1; k <= NREQ; k++) begin
        cand   = (32'(last_i) + k) % NREQ;
        req_sh = req_i >> cand;
        if (!any_c_o && req_sh[0]) begin
          any_c_o = 1'b1;
          gnt_c_o = NREQ'(1) << cand;
          idx_c_o = GRANT_W'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NREQ byte requesters: IDLE accepts a
// byte from the round-robin winner, SEND presents it until the UART takes it,
// GAP enforces GAP_CYCLES idle cycles between frames.
// Optional build macro: UART_SCHED_PRIORITY_EN (requester 0 always wins).
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic [NREQ-1:0]        req_valid_i,
  input  logic [BYTE_W*NREQ-1:0] req_data_i,
  output logic [NREQ-1:0]        req_ready_c_o,
  output logic                   tx_valid_o,
  output logic [BYTE_W-1:0]      tx_data_o,
  input  logic                   tx_ready_i,
  output logic [GRANT_W-1:0]     grant_id_o,
  output logic                   busy_o
);

  localparam logic [GAP_W-1:0]   GAP_LAST = (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);
  localparam logic [GRANT_W-1:0] LAST_RST = GRANT_W'(NREQ - 1);

  state_e                   state_q, state_d;
  logic [GAP_W-1:0]         gap_cnt_q, gap_cnt_d;
  logic [GRANT_W-1:0]       last_grant_q, last_grant_d;
  logic [GRANT_W-1:0]       grant_q, grant_d;
  logic [BYTE_W-1:0]        tx_data_q, tx_data_d;
  logic                     tx_valid_q, tx_valid_d;
  logic                     busy_q, busy_d;
  logic [NREQ-1:0]          arb_gnt;
  logic [GRANT_W-1:0]       arb_idx;
  logic                     arb_any;
  logic [BYTE_W*NREQ-1:0]   data_sh;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req_i   (req_valid_i),
    .last_i  (last_grant_q),
    .gnt_c_o (arb_gnt),
    .idx_c_o (arb_idx),
    .any_c_o (arb_any)
  );

  // State register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (arb_any) state_d = ST_SEND;
      ST_SEND: if (tx_ready_i) state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:  if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Accept strobe and next values of the registered outputs/counters
  always_comb begin
    req_ready_c_o = '0;
    gap_cnt_d     = gap_cnt_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    tx_data_d     = tx_data_q;
    data_sh       = req_data_i >> (32'(arb_idx) * BYTE_W);
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          // Reset also masks the strobe since IDLE is the reset state
          req_ready_c_o = reset_ni ? arb_gnt : '0;
          tx_data_d     = data_sh[BYTE_W-1:0];
          grant_d       = arb_idx;
          last_grant_d  = arb_idx;
        end
      end
      ST_SEND: gap_cnt_d = '0;
      ST_GAP:  gap_cnt_d = gap_cnt_q + GAP_W'(1);
      default: gap_cnt_d = '0;
    endcase
    tx_valid_d = (state_d == ST_SEND);
    busy_d     = (state_d != ST_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      gap_cnt_q    <= '0;
      last_grant_q <= LAST_RST;
      grant_q      <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      gap_cnt_q    <= gap_cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;
  assign grant_id_o = grant_q;
  assign busy_o     = busy_q;

endmodule
